// File: rtl/dsm_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dsm_sample_scheduler
// Description : Paces stereo PCM into a delta-sigma modulator at a fixed
//               sample rate of clk/CLK_DIV. Producer pairs are buffered in a
//               small FIFO and one pair is popped per sample period. The
//               block counts underruns and provides a mute that returns both
//               channels to midscale (silence).
//               Optional feature macro: DSM_SCHED_SOFT_MUTE_EN
//                 defined   -> mute ramps toward midscale by RAMP_STEP/sample
//                 undefined -> mute snaps to midscale on the next sample tick
// Ports       : clk            system clock
//               aclr           synchronous active-high reset
//               enable         run/stop for sample clock and FIFO
//               in_left/right  pair to push; in_valid/in_ready handshake
//               mute           level request for mute
//               left/right_pcm samples to the modulator
//               sample_tick    one-cycle pulse with every pcm update slot
//               underrun       one-cycle pulse: tick found the FIFO empty
//               underrun_count saturating underrun counter
//               fifo_level     FIFO occupancy
//               muted          high while fully muted
// Revision    : 1.0 - initial release
// ============================================================================
module dsm_sample_scheduler #(
    parameter int DSM_WIDTH  = 12,
    parameter int CLK_DIV    = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int RAMP_STEP  = 16
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        enable,
    input  logic [DSM_WIDTH-1:0]        in_left,
    input  logic [DSM_WIDTH-1:0]        in_right,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        mute,
    output logic [DSM_WIDTH-1:0]        left_pcm,
    output logic [DSM_WIDTH-1:0]        right_pcm,
    output logic                        sample_tick,
    output logic                        underrun,
    output logic [15:0]                 underrun_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        muted
);

    localparam int c_div_w = $clog2(CLK_DIV);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    localparam logic [DSM_WIDTH-1:0] c_mid       = DSM_WIDTH'(1) << (DSM_WIDTH - 1);
    localparam logic [DSM_WIDTH-1:0] c_ramp_step = DSM_WIDTH'(RAMP_STEP);
    localparam logic [c_div_w-1:0]   c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_lvl_w-1:0]   c_depth     = c_lvl_w'(FIFO_DEPTH);

`ifdef DSM_SCHED_SOFT_MUTE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_MUTING = 2'd2,
        ST_MUTED  = 2'd3
    } state_t;

    // Move one step toward midscale, never overshooting it.
    function automatic logic [DSM_WIDTH-1:0] ramp_to_mid(input logic [DSM_WIDTH-1:0] v);
        logic [DSM_WIDTH-1:0] diff;
        if (v > c_mid) begin
            diff = v - c_mid;
            ramp_to_mid = (diff > c_ramp_step) ? (v - c_ramp_step) : c_mid;
        end else begin
            diff = c_mid - v;
            ramp_to_mid = (diff > c_ramp_step) ? (v + c_ramp_step) : c_mid;
        end
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_MUTED = 2'd3
    } state_t;

    // The ramp step has no role when mute is a hard snap.
    logic w_unused_ramp;
    assign w_unused_ramp = ^c_ramp_step;
`endif

    state_t                   state_q, state_d;
    logic [c_div_w-1:0]       div_q, div_d;
    logic [c_ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0]       level_q, level_d;
    logic [DSM_WIDTH-1:0]     left_q, left_d;
    logic [DSM_WIDTH-1:0]     right_q, right_d;
    logic                     tick_q, tick_d;
    logic                     underrun_q, underrun_d;
    logic [15:0]              ucnt_q, ucnt_d;
    logic [2*DSM_WIDTH-1:0]   mem_q [FIFO_DEPTH];

    logic                     w_tick;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_flush;
    logic [2*DSM_WIDTH-1:0]   w_head;

    assign w_full   = (level_q == c_depth);
    assign w_empty  = (level_q == '0);
    // Readiness follows enable directly. The only cycle IDLE can see
    // enable=1 is its exit edge, where the FIFO is already empty, so a
    // pair accepted there is simply the first pair of the run.
    assign in_ready = enable && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_head   = mem_q[rd_ptr_q];
    // Tick is the divider wrap edge; stopping enable also stops the tick.
    assign w_tick   = enable && (state_q != ST_IDLE) && (div_q == c_div_last);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        left_d     = left_q;
        right_d    = right_q;
        tick_d     = 1'b0;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        w_pop      = 1'b0;
        w_flush    = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            div_d   = '0;
            left_d  = c_mid;
            right_d = c_mid;
            w_flush = 1'b1;
        end else begin
            if (state_q != ST_IDLE) begin
                div_d = (div_q == c_div_last) ? '0 : div_q + c_div_w'(1);
            end
            tick_d = w_tick;

            case (state_q)
                ST_IDLE: begin
                    left_d  = c_mid;
                    right_d = c_mid;
                    state_d = mute ? ST_MUTED : ST_RUN;
                end

                ST_RUN: begin
                    if (w_tick) begin
                        // Occupancy before the edge decides; a pair pushed on
                        // this same edge is not visible to this pop.
                        if (!w_empty) begin
                            w_pop   = 1'b1;
                            left_d  = w_head[2*DSM_WIDTH-1:DSM_WIDTH];
                            right_d = w_head[DSM_WIDTH-1:0];
                        end else begin
                            underrun_d = 1'b1;
                            if (ucnt_q != 16'hFFFF) begin
                                ucnt_d = ucnt_q + 16'd1;
                            end
                        end
                    end
`ifdef DSM_SCHED_SOFT_MUTE_EN
                    if (mute) state_d = ST_MUTING;
`else
                    if (mute) state_d = ST_MUTED;
`endif
                end

`ifdef DSM_SCHED_SOFT_MUTE_EN
                ST_MUTING: begin
                    if (w_tick) begin
                        w_pop   = !w_empty;
                        left_d  = ramp_to_mid(left_q);
                        right_d = ramp_to_mid(right_q);
                    end
                    if (!mute) begin
                        state_d = ST_RUN;
                    end else if (w_tick && (left_d == c_mid) && (right_d == c_mid)) begin
                        state_d = ST_MUTED;
                    end
                end
`endif

                ST_MUTED: begin
                    // Without the ramp, this is where a hard mute snaps to
                    // silence; with it, pcm is already midscale here.
                    if (w_tick) begin
                        w_pop   = !w_empty;
                        left_d  = c_mid;
                        right_d = c_mid;
                    end
                    if (!mute) state_d = ST_RUN;
                end

                default: begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    left_d  = c_mid;
                    right_d = c_mid;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            if (w_push && !w_pop) begin
                level_d = level_q + c_lvl_w'(1);
            end else if (!w_push && w_pop) begin
                level_d = level_q - c_lvl_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            left_q     <= c_mid;
            right_q    <= c_mid;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            left_q     <= left_d;
            right_q    <= right_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    // Storage needs no reset; pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {in_left, in_right};
        end
    end

    assign left_pcm       = left_q;
    assign right_pcm      = right_q;
    assign sample_tick    = tick_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;
    assign fifo_level     = level_q;
    assign muted          = (state_q == ST_MUTED);

endmodule
`default_nettype wire

// File: tb/tb_dsm_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsm_sample_scheduler
// Description : Scoreboard bench for dsm_sample_scheduler (CLK_DIV=16,
//               FIFO_DEPTH=4). Stimulus queues the expected content of every
//               sample tick; a monitor pops and compares on each tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsm_sample_scheduler;

    localparam int c_w   = 12;
    localparam int c_div = 16;
    localparam int c_mid = 2048;

    typedef struct {
        int l;
        int r;
        int ur;
        int uc;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             aclr;
    logic             enable;
    logic [c_w-1:0]   in_left;
    logic [c_w-1:0]   in_right;
    logic             in_valid;
    logic             in_ready;
    logic             mute;
    logic [c_w-1:0]   left_pcm;
    logic [c_w-1:0]   right_pcm;
    logic             sample_tick;
    logic             underrun;
    logic [15:0]      underrun_count;
    logic [2:0]       fifo_level;
    logic             muted;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dsm_sample_scheduler #(
        .DSM_WIDTH  (c_w),
        .CLK_DIV    (c_div),
        .FIFO_DEPTH (4),
        .RAMP_STEP  (16)
    ) dut (
        .clk            (clk),
        .aclr           (aclr),
        .enable         (enable),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mute           (mute),
        .left_pcm       (left_pcm),
        .right_pcm      (right_pcm),
        .sample_tick    (sample_tick),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level),
        .muted          (muted)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tick(input int l, input int r, input int ur, input int uc, input int cy);
        exp_t e;
        e.l = l; e.r = r; e.ur = ur; e.uc = uc; e.cyc = cy;
        sb_q.push_back(e);
    endtask

    task automatic push_pair(input int l, input int r);
        in_left  = c_w'(l);
        in_right = c_w'(r);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Returns at the negedge on which sample_tick is seen, bounded.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 64);
        if (!sample_tick) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=no_tick required=tick (cycle %0d)", cyc);
        end
    endtask

    // Monitor: every tick is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (sample_tick) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick actual=tick required=none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("tick_cycle",     cyc,                 e.cyc);
                chk("tick_left",      int'(left_pcm),      e.l);
                chk("tick_right",     int'(right_pcm),     e.r);
                chk("tick_underrun",  int'(underrun),      e.ur);
                chk("tick_ucount",    int'(underrun_count), e.uc);
            end
        end else if (underrun) begin
            checks++;
            failures++;
            $display("FAIL underrun_no_tick actual=1 required=0 (cycle %0d)", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        aclr = 1'b1; enable = 1'b0; mute = 1'b0;
        in_valid = 1'b0; in_left = '0; in_right = '0;

        // Reset / IDLE
        step(); step();
        aclr = 1'b0;
        step();
        chk("rst_left",     int'(left_pcm),       c_mid);
        chk("rst_right",    int'(right_pcm),      c_mid);
        chk("rst_in_ready", int'(in_ready),       0);
        chk("rst_level",    int'(fifo_level),     0);
        chk("rst_ucount",   int'(underrun_count), 0);
        chk("rst_muted",    int'(muted),          0);
        repeat (100) step();

        // Pacing and underrun
        c0 = cyc;
        enable = 1'b1;
        expect_tick(127,  1024, 0, 0, c0 + 17);
        expect_tick(0,    3750, 0, 0, c0 + 33);
        expect_tick(2048, 0,    0, 0, c0 + 49);
        expect_tick(2048, 0,    1, 1, c0 + 65);
        push_pair(127, 1024);
        push_pair(0, 3750);
        push_pair(2048, 0);
        repeat (4) wait_tick();
        step();
        enable = 1'b0;
        step();
        chk("disable_left",  int'(left_pcm),  c_mid);
        chk("disable_right", int'(right_pcm), c_mid);

        // Full FIFO / back-pressure
        c0 = cyc;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_tick(100 + 200 * i, 200 + 200 * i, 0, 1, c0 + 17 + 16 * i);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_left  = c_w'(100 + 200 * i);
            in_right = c_w'(200 + 200 * i);
            step();
        end
        chk("full_in_ready", int'(in_ready),   0);
        chk("full_level",    int'(fifo_level), 4);
        in_left  = c_w'(900);
        in_right = c_w'(1000);
        wait_tick();
        chk("pop_level",    int'(fifo_level), 3);
        chk("pop_in_ready", int'(in_ready),   1);
        step();
        in_valid = 1'b0;
        chk("refill_level", int'(fifo_level), 4);
        repeat (4) wait_tick();
        step();
        enable = 1'b0;
        step();

        // Same-edge push and pop on an empty FIFO
        c0 = cyc;
        enable = 1'b1;
        expect_tick(c_mid, c_mid, 1, 2, c0 + 17);
        expect_tick(1111,  2222,  0, 2, c0 + 33);
        repeat (16) step();
        push_pair(1111, 2222);
        chk("same_edge_level", int'(fifo_level), 1);
        repeat (2) wait_tick();
        step();
        enable = 1'b0;
        step();

`ifdef DSM_SCHED_SOFT_MUTE_EN
        // Soft mute ramp
        c0 = cyc;
        enable = 1'b1;
        expect_tick(2100, 1990, 0, 2, c0 + 17);
        expect_tick(2084, 2006, 0, 2, c0 + 33);
        expect_tick(2068, 2022, 0, 2, c0 + 49);
        expect_tick(2052, 2038, 0, 2, c0 + 65);
        expect_tick(2048, 2048, 0, 2, c0 + 81);
        expect_tick(7,    8,    0, 2, c0 + 97);
        push_pair(2100, 1990);
        wait_tick();
        step();
        mute = 1'b1;
        step();
        chk("muting_muted", int'(muted),    0);
        chk("muting_hold",  int'(left_pcm), 2100);
        repeat (4) wait_tick();
        chk("ramp_done_muted", int'(muted), 1);
        step();
        mute = 1'b0;
        push_pair(7, 8);
        wait_tick();
`else
        // Hard mute
        c0 = cyc;
        enable = 1'b1;
        expect_tick(3000,  1000,  0, 2, c0 + 17);
        expect_tick(c_mid, c_mid, 0, 2, c0 + 33);
        expect_tick(7,     8,     0, 2, c0 + 49);
        push_pair(3000, 1000);
        push_pair(5, 6);
        wait_tick();
        step();
        mute = 1'b1;
        step();
        chk("hard_muted",      int'(muted),      1);
        chk("hard_hold_left",  int'(left_pcm),   3000);
        chk("hard_hold_right", int'(right_pcm),  1000);
        chk("hard_level",      int'(fifo_level), 1);
        wait_tick();
        step();
        chk("muted_discard_level", int'(fifo_level), 0);
        mute = 1'b0;
        push_pair(7, 8);
        wait_tick();
`endif

        // Reset in RUN with entries queued
        push_pair(11, 12);
        push_pair(13, 14);
        push_pair(15, 16);
        chk("pre_reset_level", int'(fifo_level), 3);
        aclr = 1'b1;
        step();
        chk("mid_rst_level",  int'(fifo_level),     0);
        chk("mid_rst_ucount", int'(underrun_count), 0);
        chk("mid_rst_left",   int'(left_pcm),       c_mid);
        chk("mid_rst_right",  int'(right_pcm),      c_mid);
        chk("mid_rst_muted",  int'(muted),          0);
        chk("mid_rst_tick",   int'(sample_tick),    0);
        c0 = cyc;
        aclr = 1'b0;
        // Back in IDLE: a fresh run starts its divider from zero.
        expect_tick(c_mid, c_mid, 1, 1, c0 + 17);
        wait_tick();
        step();
        enable = 1'b0;
        repeat (20) step();

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
